// File: rtl/dcnt_eqz.sv
// Loadable down-counter with zero detect, threshold flag and a start/done handshake.
// Optional build macro DCNT_AUTORELOAD_EN: FIN reloads from the last loaded value and repeats the run.
module dcnt_eqz #(
    parameter int WIDTH  = 16,
    parameter int THRESH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             eq,
    output logic             near,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] THRESH_W = WIDTH'(THRESH);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= ZERO;
            rld_q   <= ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
        end
    end

    // Load wins over decrement in every state; a zero load finishes at once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        if (ld) begin
            cnt_d   = din;
            rld_d   = din;
            state_d = (din != ZERO) ? COUNT : FIN;
        end else begin
            case (state_q)
                COUNT: begin
                    if (dec && (cnt_q != ZERO)) begin
                        cnt_d = cnt_q - ONE;
                        if (cnt_q == ONE) begin
                            state_d = FIN;
                        end
                    end
                end
                FIN: begin
`ifdef DCNT_AUTORELOAD_EN
                    cnt_d   = rld_q;
                    state_d = (rld_q != ZERO) ? COUNT : IDLE;
`else
                    state_d = IDLE;
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign cnt  = cnt_q;
    assign eq   = (cnt_q == ZERO);
    assign near = (cnt_q <= THRESH_W);
    assign busy = (state_q == COUNT);
    assign done = (state_q == FIN);

endmodule

// File: tb/tb_dcnt_eqz.sv
// Directed bench for dcnt_eqz (default build, WIDTH=16, THRESH=1).
module tb_dcnt_eqz;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld;
    logic [15:0] din;
    logic        dec;
    logic [15:0] cnt;
    logic        eq;
    logic        near;
    logic        busy;
    logic        done;

    int tests  = 0;
    int failed = 0;

    dcnt_eqz #(.WIDTH(16), .THRESH(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .din  (din),
        .dec  (dec),
        .cnt  (cnt),
        .eq   (eq),
        .near (near),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] c, input logic e,
                           input logic n, input logic b, input logic d);
        chk({tag, ".cnt"},  32'(cnt),  32'(c));
        chk({tag, ".eq"},   32'(eq),   32'(e));
        chk({tag, ".near"}, 32'(near), 32'(n));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    initial begin
        logic [15:0] exp_c;
        rst = 1'b1; ld = 1'b0; din = '0; dec = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_all("reset", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Idle with dec high: nothing moves
        dec = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("idle_dec", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // Load 5, count to zero
        ld = 1'b1; din = 16'd5;
        step();
        ld = 1'b0;
        chk_all("run5_c5", 16'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            step();
            exp_c = 16'(i);
            chk_all("run5", exp_c, (i == 0), (i <= 1), (i != 0), (i == 0));
        end
        step();
        chk_all("run5_idle", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Zero load goes straight to FIN
        ld = 1'b1; din = 16'd0;
        step();
        ld = 1'b0;
        chk_all("zero_fin", 16'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk_all("zero_idle", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Load 4, hold at 2, then reload 3 mid-run
        ld = 1'b1; din = 16'd4;
        step();
        ld = 1'b0;
        chk_all("hold_c4", 16'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        chk_all("hold_c2", 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        dec = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("hold_dec0", 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        ld = 1'b1; din = 16'd3; dec = 1'b1;
        step();
        ld = 1'b0;
        chk_all("reld_c3", 16'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("reld_c2", 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("reld_c1", 16'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("reld_c0", 16'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk_all("reld_idle", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset together with load mid-run
        ld = 1'b1; din = 16'd4;
        step();
        ld = 1'b0;
        step();
        step();
        chk_all("rst_pre", 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1; ld = 1'b1; din = 16'd9;
        step();
        rst = 1'b0; ld = 1'b0;
        chk_all("rst_mid", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("rst_after", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Load while in FIN
        ld = 1'b1; din = 16'd2;
        step();
        ld = 1'b0;
        step();
        step();
        chk_all("fin_pre", 16'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        ld = 1'b1; din = 16'd7;
        #1;
        chk_all("fin_ld_same", 16'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        ld = 1'b0;
        chk_all("fin_ld_next", 16'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step();
        chk_all("fin_run_c1", 16'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("fin_run_done", 16'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk_all("fin_run_idle", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("fin_run_stay", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Full-scale load
        ld = 1'b1; din = 16'hFFFF;
        step();
        ld = 1'b0;
        chk_all("max_start", 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 65534; i++) step();
        chk_all("max_c1", 16'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("max_done", 16'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk_all("max_idle", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
